// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct, executes single-cycle ops or an iterative
// shift-add MULT, and holds the result behind a valid/ready handshake.
// Optional signed restoring divider (funct 0x1A) enabled by defining ALU_DIV_EN.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             bad_op
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE, S_DIV} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_BAD} op_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             bad_q, bad_d;

    op_t              op_dec;
    logic [WIDTH-1:0] sum, diff, abs_a, abs_b, sc_lo;
    logic             sc_ovf;
    logic [W2-1:0]    mul_step, mul_final;

`ifdef ALU_DIV_EN
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH:0]   div_shift, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, div_quot, div_lo, div_hi;
`endif

    always_comb begin
        op_dec = OP_BAD;
        case (alu_op)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b11: op_dec = OP_OR;
            default: begin
                case (funct)
                    6'h20: op_dec = OP_ADD;
                    6'h22: op_dec = OP_SUB;
                    6'h24: op_dec = OP_AND;
                    6'h25: op_dec = OP_OR;
                    6'h2A: op_dec = OP_SLT;
                    6'h18: op_dec = OP_MUL;
`ifdef ALU_DIV_EN
                    6'h1A: op_dec = OP_DIV;
`endif
                    default: op_dec = OP_BAD;
                endcase
            end
        endcase
    end

    // Single-cycle datapath and operand magnitudes for the iterative ops
    always_comb begin
        sum    = op_a + op_b;
        diff   = op_a - op_b;
        abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
        abs_b  = op_b[WIDTH-1] ? -op_b : op_b;
        sc_lo  = '0;
        sc_ovf = 1'b0;
        case (op_dec)
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo  = diff;
                sc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  sc_lo = op_a & op_b;
            OP_OR:   sc_lo = op_a | op_b;
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: sc_lo = '0;
        endcase
    end

    always_comb begin
        mul_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_final = neg_q ? -mul_step : mul_step;
    end

`ifdef ALU_DIV_EN
    // Remainder lives in acc_q[WIDTH-1:0]; dividend bits shift out of mplier_q as quotient bits shift in
    always_comb begin
        div_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        div_sub   = div_shift - {1'b0, mcand_q[WIDTH-1:0]};
        div_ge    = (div_shift >= {1'b0, mcand_q[WIDTH-1:0]});
        div_rem   = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quot  = {mplier_q[WIDTH-2:0], div_ge};
        div_lo    = dz_q ? '1 : (neg_q ? -div_quot : div_quot);
        div_hi    = dz_q ? a_raw_q : (rneg_q ? -div_rem : div_rem);
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        bad_d    = bad_q;
`ifdef ALU_DIV_EN
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        a_raw_d  = a_raw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    if (op_dec == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
`ifdef ALU_DIV_EN
                    end else if (op_dec == OP_DIV) begin
                        state_d  = S_DIV;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, abs_b};
                        mplier_d = abs_a;
                        rneg_d   = op_a[WIDTH-1];
                        dz_d     = (op_b == '0);
                        a_raw_d  = op_a;
`endif
                    end else begin
                        state_d  = S_DONE;
                        res_lo_d = sc_lo;
                        res_hi_d = '0;
                        zero_d   = (sc_lo == '0);
                        ovf_d    = sc_ovf;
                        bad_d    = (op_dec == OP_BAD);
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_lo_d = mul_final[WIDTH-1:0];
                    res_hi_d = mul_final[W2-1:WIDTH];
                    zero_d   = (mul_final[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    bad_d    = 1'b0;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                acc_d    = {{WIDTH{1'b0}}, div_rem};
                mplier_d = div_quot;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_lo_d = div_lo;
                    res_hi_d = div_hi;
                    zero_d   = (div_lo == '0);
                    ovf_d    = 1'b0;
                    bad_d    = dz_q;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
`ifdef ALU_DIV_EN
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            a_raw_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
`ifdef ALU_DIV_EN
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            a_raw_q  <= a_raw_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign bad_op    = bad_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor to the ALU control decoder. It decodes ALUOp and the MIPS funct field, executes the operation, and registers the result behind a valid/ready handshake. Single-cycle ops (ADD/SUB/AND/OR/SLT) complete in one cycle. MULT runs as an iterative shift-add multiply that holds off new issue while busy. It sits in the EX stage between the main control unit and the EX/MEM register.

Parameters:
WIDTH, 32, operand width in bits (≥4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands/opcode present
in_ready  out  1  unit can accept (high only in IDLE)
alu_op  in  2  00=ADD, 01=SUB, 10=R-type (use funct), 11=OR
funct  in  6  MIPS funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x18 MULT, 0x1A DIV (macro only)
op_a  in  WIDTH  operand A (rs)
op_b  in  WIDTH  operand B (rt/imm)
out_valid  out  1  result registered and valid
out_ready  in  1  consumer accepts result
result_lo  out  WIDTH  primary result / low product / quotient
result_hi  out  WIDTH  high product / remainder; 0 for single-cycle ops
zero  out  1  result_lo == 0
ovf  out  1  signed overflow (ADD/SUB only, else 0)
bad_op  out  1  unsupported funct on alu_op=10; result 0

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, result_lo=0, result_hi=0, zero=0, ovf=0, bad_op=0, counter=0. Reset has priority over everything, including an in-flight MULT, which is aborted with no output.
- Issue: a transfer occurs when in_valid && in_ready at a clk edge. Operands and the decoded op are latched on that edge.
- States: IDLE, MUL, DONE (plus DIV with the macro).
- IDLE + single-cycle op → DONE next edge; results are registered on the issue edge. Latency: out_valid=1 the cycle after issue.
- IDLE + MULT → MUL. Signed operands are converted to magnitudes and the result sign is recorded; counter=0.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator; counter++. After WIDTH steps → DONE, with sign correction applied and {result_hi,result_lo} loaded. Latency: out_valid on cycle WIDTH+1 after issue.
- DONE: out_valid=1, outputs stable. When out_ready=1 at an edge → IDLE, out_valid=0.
- No back-to-back bypass: in_ready=0 in DONE even when out_ready=1. Max throughput is one op per 2 cycles.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. ovf = operand signs match (ADD), or differ (SUB), and result sign differs from op_a. SLT is signed: result_lo = {WIDTH-1 zeros, (a<b)}.
- Decode: alu_op 00/01/11 ignore funct. alu_op=10 with an unlisted funct sets bad_op=1, result_lo=result_hi=0, zero=1, and still completes in 1 cycle.
- in_valid while busy is ignored; the upstream stage must hold its data until accepted.
- MULT edge cases: the most negative value × -1 yields the exact 2*WIDTH-bit product (no overflow flag). × 0 gives 0 with zero=1.

Optional Feature:
ALU_DIV_EN. Defined: funct 0x1A runs a signed restoring divide in state DIV, WIDTH steps, same latency as MULT. result_lo=quotient (truncated toward zero), result_hi=remainder (sign of dividend). Divide by zero: quotient all ones, remainder=op_a, bad_op=1. Undefined: 0x1A is treated as unsupported (bad_op=1, 1-cycle completion) and no divider logic is synthesised.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles during a MULT → out_valid=0, in_ready=1, all outputs 0 after release.
2. ADD overflow: alu_op=00, a=0x7FFFFFFF, b=1 → next cycle out_valid=1, result_lo=0x80000000, ovf=1, zero=0. SUB a=5, b=5 → result_lo=0, zero=1, ovf=0.
3. R-type decode: funct 0x2A, a=0xFFFFFFFF(-1), b=1 → result_lo=1. funct 0x3F → bad_op=1, result_lo=0.
4. MULT: a=0xFFFFFFFE(-2), b=3 → out_valid exactly 33 cycles after issue, result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA. in_ready=0 throughout.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, a new in_valid is not accepted. Raise out_ready → IDLE next cycle.
6. With ALU_DIV_EN: a=-7, b=2 → result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF. b=0 → bad_op=1, result_lo=0xFFFFFFFF.
